// File: rtl/dpram_bist_pkg.sv
// Shared constants for the DPRAM march-test initiator:
// FSM state codes, march phase codes and watchdog limit.
package dpram_bist_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    localparam logic [7:0] TIMEOUT_MAX = 8'd255;

endpackage

// File: rtl/dpram_bist_initiator_if.sv
// Request port between the BIST initiator (master)
// and the DPRAM controller (slave).
interface dpram_bist_initiator_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              RD;
    logic              WR;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] DIn;
    logic              Done;
    logic [DATA_W-1:0] DOut;

    modport master (output RD, WR, A, DIn, input Done, DOut);
    modport slave  (input RD, WR, A, DIn, output Done, DOut);
endinterface

// File: rtl/dpram_bist_pattern.sv
// March data word: d(a) = PATTERN ^ a, inverted for the
// P1 write-back and for every P2 access.
module dpram_bist_pattern
    import dpram_bist_pkg::*;
#(
    parameter int                ADDR_W  = 10,
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(16'hA5C3)
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        phase_i,
    input  logic              wr_i,
    output logic [DATA_W-1:0] word_o
);
    logic [DATA_W-1:0] base;
    logic              inv;

    assign base   = PATTERN ^ DATA_W'(addr_i);
    assign inv    = (phase_i == P2) || ((phase_i == P1) && wr_i);
    assign word_o = inv ? ~base : base;
endmodule

// File: rtl/dpram_bist_initiator.sv
// 3-phase march BIST initiator for the DPRAM request port.
// Define DPRAM_BIST_TIMEOUT_EN to add an 8-bit WAIT watchdog.
module dpram_bist_initiator
    import dpram_bist_pkg::*;
#(
    parameter int                ADDR_W  = 10,
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(16'hA5C3)
) (
    input  logic                  clk,
    input  logic                  ar,
    input  logic                  start,
    dpram_bist_initiator_if.master bus,
    output logic                  busy,
    output logic                  test_done,
    output logic                  pass,
    output logic                  fail,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [DATA_W-1:0]     fail_exp,
    output logic [DATA_W-1:0]     fail_got
);
    localparam logic [ADDR_W-1:0] AMAX = '1;

    logic [2:0]        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              tdone_q, tdone_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fexp_q, fexp_d;
    logic [DATA_W-1:0] fgot_q, fgot_d;
    logic [DATA_W-1:0] pat;
`ifdef DPRAM_BIST_TIMEOUT_EN
    logic [7:0]        wdog_q, wdog_d;
`endif

    dpram_bist_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PATTERN(PATTERN)
    ) u_pat (
        .addr_i (addr_q),
        .phase_i(phase_q),
        .wr_i   (wr_q),
        .word_o (pat)
    );

    assign bus.RD  = (state_q == S_REQ) && !wr_q;
    assign bus.WR  = (state_q == S_REQ) && wr_q;
    assign bus.A   = addr_q;
    assign bus.DIn = (wr_q && ((state_q == S_REQ) || (state_q == S_WAIT))) ? pat : '0;

    assign busy      = busy_q;
    assign test_done = tdone_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_addr = faddr_q;
    assign fail_exp  = fexp_q;
    assign fail_got  = fgot_q;

    // march sequencing, compare and sticky result next-state
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        tdone_d = tdone_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        faddr_d = faddr_q;
        fexp_d  = fexp_q;
        fgot_d  = fgot_q;
`ifdef DPRAM_BIST_TIMEOUT_EN
        wdog_d  = wdog_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    phase_d = P0;
                    addr_d  = '0;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                    tdone_d = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    faddr_d = '0;
                    fexp_d  = '0;
                    fgot_d  = '0;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
`ifdef DPRAM_BIST_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (bus.Done) begin
                    dout_d  = bus.DOut;
                    state_d = wr_q ? S_NEXT : S_CMP;
                end
`ifdef DPRAM_BIST_TIMEOUT_EN
                else if (wdog_q == TIMEOUT_MAX) begin
                    fail_d  = 1'b1;
                    faddr_d = addr_q;
                    fexp_d  = pat;
                    fgot_d  = '0;
                    state_d = S_FINISH;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            S_CMP: begin
                if (dout_q != pat) begin
                    fail_d  = 1'b1;
                    faddr_d = addr_q;
                    fexp_d  = pat;
                    fgot_d  = dout_q;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = S_REQ;
                unique case (phase_q)
                    P0: begin
                        if (addr_q == AMAX) begin
                            phase_d = P1;
                            addr_d  = '0;
                            wr_d    = 1'b0;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                    P1: begin
                        if (!wr_q) begin
                            wr_d = 1'b1;
                        end else if (addr_q == AMAX) begin
                            phase_d = P2;
                            wr_d    = 1'b0;
                        end else begin
                            addr_d = addr_q + 1'b1;
                            wr_d   = 1'b0;
                        end
                    end
                    default: begin
                        if (addr_q == '0) begin
                            state_d = S_FINISH;
                        end else begin
                            addr_d = addr_q - 1'b1;
                        end
                    end
                endcase
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                tdone_d = 1'b1;
                pass_d  = !fail_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state_q <= S_IDLE;
            phase_q <= P0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            tdone_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
`ifdef DPRAM_BIST_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            tdone_q <= tdone_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
`ifdef DPRAM_BIST_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end
endmodule

// File: tb/tb_dpram_bist_initiator.sv
// Scoreboard bench for dpram_bist_initiator (ADDR_W=4)
// with a behavioural 2-cycle responder and fault modes.
module tb_dpram_bist_initiator;
    logic clk;
    logic ar;
    logic start;
    logic busy, test_done, pass, fail;
    logic [3:0]  fail_addr;
    logic [15:0] fail_exp, fail_got;

    dpram_bist_initiator_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    dpram_bist_initiator #(
        .ADDR_W (4),
        .DATA_W (16),
        .PATTERN(16'hA5C3)
    ) dut (
        .clk      (clk),
        .ar       (ar),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .test_done(test_done),
        .pass     (pass),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  a;
        logic [15:0] d;
    } req_t;

    typedef struct {
        logic        pass;
        logic        fail;
        logic [3:0]  a;
        logic [15:0] e;
        logic [15:0] g;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   total = 0;
    int   bad   = 0;

    // responder: 0 clean, 1 flip bit0 at a=5 in P1,
    // 2 DOut[15] stuck at 1 in P2, 3 no Done for write a=3
    int          mode = 0;
    int          rd_cnt = 0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic        done_r = 1'b0;
    logic        done_spur = 1'b0;
    logic [15:0] dout_r = '0;
    logic [15:0] rv;
    logic [15:0] mem [16];

    assign bus.Done = done_r | done_spur;
    assign bus.DOut = dout_r;

    always @(posedge clk) begin
        done_r <= 1'b0;
        if (pend) begin
            if (cnt == 1) begin
                done_r <= 1'b1;
                pend   <= 1'b0;
            end else begin
                cnt <= cnt + 1;
            end
        end
        if (start) rd_cnt <= 0;
        if (bus.WR) begin
            mem[bus.A] <= bus.DIn;
            if (!(mode == 3 && bus.A == 4'd3)) begin
                pend <= 1'b1;
                cnt  <= 0;
            end
        end
        if (bus.RD) begin
            rv = mem[bus.A];
            if (mode == 1 && bus.A == 4'd5 && rd_cnt < 16) rv[0] = ~rv[0];
            if (mode == 2 && rd_cnt >= 16) rv[15] = 1'b1;
            dout_r <= rv;
            rd_cnt <= rd_cnt + 1;
            pend   <= 1'b1;
            cnt    <= 0;
        end
    end

    function automatic logic [15:0] dval(input int a);
        logic [15:0] t;
        t = 16'(a);
        return 16'hA5C3 ^ t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push_rq(input logic w, input int a, input logic [15:0] d);
        req_t r;
        r.wr = w;
        r.a  = 4'(a);
        r.d  = d;
        req_q.push_back(r);
    endtask

    task automatic push_res(input logic p, input logic f, input int a,
                            input logic [15:0] e, input logic [15:0] g);
        res_t r;
        r.pass = p;
        r.fail = f;
        r.a    = 4'(a);
        r.e    = e;
        r.g    = g;
        res_q.push_back(r);
    endtask

    task automatic push_p0();
        for (int a = 0; a < 16; a++) push_rq(1'b1, a, dval(a));
    endtask

    task automatic push_p1(input int n);
        for (int a = 0; a < n; a++) begin
            push_rq(1'b0, a, 16'h0);
            push_rq(1'b1, a, ~dval(a));
        end
    endtask

    task automatic push_full();
        push_p0();
        push_p1(16);
        for (int a = 15; a >= 0; a--) push_rq(1'b0, a, 16'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!test_done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", 64'(test_done), 64'(1));
    endtask

    task automatic settle_and_drain(input string nm);
        repeat (12) @(negedge clk);
        chk({nm, "_reqs_left"}, 64'(req_q.size()), 64'(0));
        chk({nm, "_res_left"}, 64'(res_q.size()), 64'(0));
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, 64'({bus.RD, bus.WR, bus.A, bus.DIn, busy, test_done,
                     pass, fail, fail_addr, fail_exp, fail_got}), 64'(0));
    endtask

    // monitor: pops expected requests and results as the DUT shows them
    req_t mon_e;
    res_t mon_r;
    logic td_prev = 1'b0;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.RD || bus.WR) begin
                if (req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req rd=%0b wr=%0b a=%0d",
                             bus.RD, bus.WR, bus.A);
                end else begin
                    mon_e = req_q.pop_front();
                    chk("req_onehot", 64'(bus.RD ^ bus.WR), 64'(1));
                    chk("req_kind", 64'(bus.WR), 64'(mon_e.wr));
                    chk("req_addr", 64'(bus.A), 64'(mon_e.a));
                    if (mon_e.wr) chk("req_data", 64'(bus.DIn), 64'(mon_e.d));
                end
            end
            if (test_done && !td_prev) begin
                if (res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done pass=%0b fail=%0b", pass, fail);
                end else begin
                    mon_r = res_q.pop_front();
                    chk("res_busy", 64'(busy), 64'(0));
                    chk("res_pass", 64'(pass), 64'(mon_r.pass));
                    chk("res_fail", 64'(fail), 64'(mon_r.fail));
                    chk("res_addr", 64'(fail_addr), 64'(mon_r.a));
                    chk("res_exp", 64'(fail_exp), 64'(mon_r.e));
                    chk("res_got", 64'(fail_got), 64'(mon_r.g));
                end
            end
            td_prev = test_done;
        end
    end

    initial begin
        start = 1'b0;
        ar    = 1'b0;
        #1;
        chk_all_zero("reset_outputs");
        repeat (3) @(negedge clk);
        ar = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_outputs");

        // 1: clean run
        mode = 0;
        push_full();
        push_res(1'b1, 1'b0, 0, 16'h0, 16'h0);
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'(1));
        wait_done(2000);
        settle_and_drain("t1");

        // 2: bit0 flip on P1 read at a=5
        mode = 1;
        push_p0();
        push_p1(5);
        push_rq(1'b0, 5, 16'h0);
        push_res(1'b0, 1'b1, 5, 16'hA5C6, 16'hA5C7);
        pulse_start();
        chk("start_clears_done", 64'({test_done, pass, fail_addr}), 64'(0));
        wait_done(2000);
        settle_and_drain("t2");

        // 3: DOut[15] stuck high during P2
        mode = 2;
        push_full();
        void'(req_q.pop_back());
        for (int k = 0; k < 14; k++) void'(req_q.pop_back());
        push_res(1'b0, 1'b1, 15, 16'h5A33, 16'hDA33);
        pulse_start();
        wait_done(2000);
        settle_and_drain("t3");

        // 4: reset during WAIT in P1
        mode = 0;
        push_p0();
        push_p1(2);
        push_rq(1'b0, 2, 16'h0);
        pulse_start();
        for (int n = 0; n < 500 && req_q.size() != 0; n++) @(negedge clk);
        chk("t4_reached_p1", 64'(req_q.size()), 64'(0));
        @(posedge clk);
        #1;
        ar = 1'b0;
        #1;
        chk_all_zero("t4_async_reset");
        #1;
        ar = 1'b1;
        repeat (10) @(negedge clk);
        chk("t4_idle_after_done", 64'({busy, test_done}), 64'(0));
        push_full();
        push_res(1'b1, 1'b0, 0, 16'h0, 16'h0);
        pulse_start();
        wait_done(2000);
        settle_and_drain("t4");

        // 5: spurious Done in IDLE, start while busy
        @(negedge clk);
        done_spur = 1'b1;
        @(negedge clk);
        done_spur = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_spur_done", 64'({busy, test_done, pass}), 64'(3'b011));
        push_full();
        push_res(1'b1, 1'b0, 0, 16'h0, 16'h0);
        pulse_start();
        repeat (40) @(negedge clk);
        pulse_start();
        wait_done(2000);
        settle_and_drain("t5");

`ifdef DPRAM_BIST_TIMEOUT_EN
        // 6: no Done for the P0 write at a=3
        mode = 3;
        for (int a = 0; a < 4; a++) push_rq(1'b1, a, dval(a));
        push_res(1'b0, 1'b1, 3, 16'hA5C0, 16'h0);
        pulse_start();
        wait_done(1000);
        settle_and_drain("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
